// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host init controller.
//  - state_e     : controller FSM encoding (also exported on dbg_state)
//  - CMD_*/RSP_* : keyboard command and response bytes
//  - INIT_SEQ    : bytes sent in order during initialisation
//  - odd_parity  : PS/2 parity bit for a data byte
package ps2_pkg;

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StInhibit  = 4'd1,
    StStart    = 4'd2,
    StTxBits   = 4'd3,
    StTxAck    = 4'd4,
    StWaitIdle = 4'd5,
    StWaitResp = 4'd6,
    StWaitBat  = 4'd7,
    StNext     = 4'd8,
    StDone     = 4'd9,
    StError    = 4'd10
  } state_e;

  localparam logic [7:0] CMD_RESET       = 8'hFF;
  localparam logic [7:0] CMD_TYPEMATIC   = 8'hF3;
  localparam logic [7:0] CMD_ENABLE      = 8'hF4;
  localparam logic [7:0] PARAM_TYPEMATIC = 8'h00;

  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;

  // Index 0 is the first byte sent.
  localparam logic [0:3][7:0] INIT_SEQ = {CMD_RESET, CMD_TYPEMATIC, PARAM_TYPEMATIC, CMD_ENABLE};

  function automatic logic odd_parity(input logic [7:0] b);
    return ~(^b);
  endfunction

endpackage

// File: rtl/ps2_tx_shifter.sv
// Host->device PS/2 byte transmitter.
//  Synchronises the raw pads, detects falling clock edges and walks through the
//  11 device-generated clocks of one host->device frame.
// Ports:
//  sys_clk, reset          clock, asynchronous active-low reset
//  i_ps2_clk, i_ps2_dat    raw pad inputs (asynchronous)
//  i_go                    load i_byte and pull data low (start bit)
//  i_abort                 drop the frame and release data
//  i_byte                  byte to send
//  o_dat_oe                1 = pull data low
//  o_busy                  frame in progress
//  o_ack_phase             stop bit sent, waiting for the device ack clock
//  o_acked, o_nack         1-cycle result of the ack clock (data low / high)
//  o_clk_sync, o_dat_sync  synchronised pad levels
module ps2_tx_shifter
  import ps2_pkg::*;
(
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  input  logic       i_go,
  input  logic       i_abort,
  input  logic [7:0] i_byte,
  output logic       o_dat_oe,
  output logic       o_busy,
  output logic       o_ack_phase,
  output logic       o_acked,
  output logic       o_nack,
  output logic       o_clk_sync,
  output logic       o_dat_sync
);

  logic       r_clk_meta, r_clk_sync, r_clk_prev;
  logic       r_dat_meta, r_dat_sync;
  logic [8:0] r_shift, w_shift_nxt;
  logic [3:0] r_edge_cnt, w_edge_cnt_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_dat_oe, w_dat_oe_nxt;
  logic       r_acked, w_acked_nxt;
  logic       r_nack, w_nack_nxt;
  logic       w_clk_fall;

  // Idle bus is high, so the synchronisers reset to 1.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      r_clk_meta <= 1'b1;
      r_clk_sync <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_meta <= 1'b1;
      r_dat_sync <= 1'b1;
    end else begin
      r_clk_meta <= i_ps2_clk;
      r_clk_sync <= r_clk_meta;
      r_clk_prev <= r_clk_sync;
      r_dat_meta <= i_ps2_dat;
      r_dat_sync <= r_dat_meta;
    end
  end

  assign w_clk_fall = r_clk_prev & ~r_clk_sync;

  // r_edge_cnt holds the number of falling edges already seen in this frame.
  always_comb begin
    w_shift_nxt    = r_shift;
    w_edge_cnt_nxt = r_edge_cnt;
    w_busy_nxt     = r_busy;
    w_dat_oe_nxt   = r_dat_oe;
    w_acked_nxt    = 1'b0;
    w_nack_nxt     = 1'b0;
    if (i_abort) begin
      w_busy_nxt   = 1'b0;
      w_dat_oe_nxt = 1'b0;
    end else if (i_go) begin
      w_shift_nxt    = {odd_parity(i_byte), i_byte};
      w_edge_cnt_nxt = 4'd0;
      w_busy_nxt     = 1'b1;
      w_dat_oe_nxt   = 1'b1;
    end else if (r_busy && w_clk_fall) begin
      w_edge_cnt_nxt = r_edge_cnt + 4'd1;
      if (r_edge_cnt < 4'd9) begin
        // Edges 1..9: d0..d7 then parity, LSB first.
        w_dat_oe_nxt = ~r_shift[0];
        w_shift_nxt  = {1'b0, r_shift[8:1]};
      end else if (r_edge_cnt == 4'd9) begin
        w_dat_oe_nxt = 1'b0;
      end else begin
        // Edge 11: the device pulls data low to acknowledge.
        w_busy_nxt  = 1'b0;
        w_acked_nxt = ~r_dat_sync;
        w_nack_nxt  = r_dat_sync;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      r_shift    <= '0;
      r_edge_cnt <= '0;
      r_busy     <= 1'b0;
      r_dat_oe   <= 1'b0;
      r_acked    <= 1'b0;
      r_nack     <= 1'b0;
    end else begin
      r_shift    <= w_shift_nxt;
      r_edge_cnt <= w_edge_cnt_nxt;
      r_busy     <= w_busy_nxt;
      r_dat_oe   <= w_dat_oe_nxt;
      r_acked    <= w_acked_nxt;
      r_nack     <= w_nack_nxt;
    end
  end

  assign o_dat_oe    = r_dat_oe;
  assign o_busy      = r_busy;
  assign o_ack_phase = r_busy && (r_edge_cnt == 4'd10);
  assign o_acked     = r_acked;
  assign o_nack      = r_nack;
  assign o_clk_sync  = r_clk_sync;
  assign o_dat_sync  = r_dat_sync;

endmodule

// File: rtl/ps2_host_init_ctrl.sv
// PS/2 host init controller: sends FF, F3 00, F4 to the keyboard, checking
// each response and retrying on resend, NAK or timeout.
// Ports:
//  sys_clk, reset             clock, asynchronous active-low reset
//  start                      pulse; starts the sequence from IDLE/DONE/ERROR
//  ps2_clk_i, ps2_dat_i       raw pad inputs
//  ps2_clk_oe, ps2_dat_oe     1 = pull the line low
//  rx_valid, rx_data          bytes from the existing receiver
//  rx_enable                  0 while the host owns the bus
//  ready, error               sequence complete / retries exhausted
//  dbg_state                  current FSM state
module ps2_host_init_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned INHIBIT_US = 120,
  parameter int unsigned BYTE_TO_MS = 20,
  parameter int unsigned BAT_TO_MS  = 1000,
  parameter int unsigned RETRIES    = 3
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       start,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_enable,
  output logic       ready,
  output logic       error,
  output logic [3:0] dbg_state
);

  // 64-bit so that CLK_HZ * time never overflows before the divide.
  localparam longint unsigned InhibitCyc = 64'(INHIBIT_US) * 64'(CLK_HZ) / 64'd1_000_000;
  localparam longint unsigned ByteToCyc  = 64'(BYTE_TO_MS) * 64'(CLK_HZ) / 64'd1_000;
  localparam longint unsigned BatToCyc   = 64'(BAT_TO_MS) * 64'(CLK_HZ) / 64'd1_000;
  localparam longint unsigned MaxTo      = (ByteToCyc > BatToCyc) ? ByteToCyc : BatToCyc;
  localparam longint unsigned MaxCyc     = (MaxTo > InhibitCyc) ? MaxTo : InhibitCyc;
  localparam int unsigned     TimerW     = $clog2(MaxCyc + 64'd1);

  localparam logic [TimerW-1:0] InhibitLast = TimerW'(InhibitCyc - 64'd1);
  localparam logic [TimerW-1:0] ByteToLast  = TimerW'(ByteToCyc - 64'd1);
  localparam logic [TimerW-1:0] BatToLast   = TimerW'(BatToCyc - 64'd1);
  localparam logic [1:0]        RetryMax    = 2'(RETRIES);

  state_e            r_state, w_state_nxt;
  logic [2:0]        r_idx, w_idx_nxt;
  logic [1:0]        r_retry, w_retry_nxt;
  logic [TimerW-1:0] r_timer;
  logic              r_clk_oe, r_rx_enable, r_ready, r_error;

  logic       w_go, w_abort, w_retry_req, w_timer_clr, w_host_owns;
  logic       w_byte_to, w_bat_to;
  logic [7:0] w_cmd;
  logic       w_dat_oe, w_busy, w_ack_phase, w_acked, w_nack, w_clk_sync, w_dat_sync;

  ps2_tx_shifter u_tx (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .i_ps2_clk   (ps2_clk_i),
    .i_ps2_dat   (ps2_dat_i),
    .i_go        (w_go),
    .i_abort     (w_abort),
    .i_byte      (w_cmd),
    .o_dat_oe    (w_dat_oe),
    .o_busy      (w_busy),
    .o_ack_phase (w_ack_phase),
    .o_acked     (w_acked),
    .o_nack      (w_nack),
    .o_clk_sync  (w_clk_sync),
    .o_dat_sync  (w_dat_sync)
  );

  assign w_cmd     = INIT_SEQ[r_idx[1:0]];
  assign w_byte_to = (r_timer >= ByteToLast);
  assign w_bat_to  = (r_timer >= BatToLast);

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_retry_nxt = r_retry;
    w_go        = 1'b0;
    w_abort     = 1'b0;
    w_retry_req = 1'b0;
    unique case (r_state)
      StIdle, StDone, StError: begin
        if (start) begin
          w_idx_nxt   = 3'd0;
          w_retry_nxt = 2'd0;
          w_state_nxt = StInhibit;
        end
      end
      StInhibit: begin
        if (r_timer >= InhibitLast) begin
          w_go        = 1'b1;
          w_state_nxt = StStart;
        end
      end
      StStart, StTxBits: begin
        if (w_byte_to) begin
          w_abort     = 1'b1;
          w_retry_req = 1'b1;
        end else if (r_state == StStart && w_busy) begin
          w_state_nxt = StTxBits;
        end else if (r_state == StTxBits && w_ack_phase) begin
          w_state_nxt = StTxAck;
        end
      end
      StTxAck: begin
        if (w_acked) begin
          w_state_nxt = StWaitIdle;
        end else if (w_nack) begin
          w_retry_req = 1'b1;
        end else if (w_byte_to) begin
          w_abort     = 1'b1;
          w_retry_req = 1'b1;
        end
      end
      StWaitIdle: begin
        if (w_clk_sync && w_dat_sync) begin
          w_state_nxt = StWaitResp;
        end else if (w_byte_to) begin
          w_retry_req = 1'b1;
        end
      end
      StWaitResp: begin
        // A received byte takes priority over a timeout in the same cycle.
        if (rx_valid) begin
          if (rx_data == RSP_ACK) begin
            if (w_cmd == CMD_RESET) begin
              w_state_nxt = StWaitBat;
            end else begin
              w_idx_nxt   = r_idx + 3'd1;
              w_state_nxt = StNext;
            end
          end else if (rx_data == RSP_RESEND) begin
            w_retry_req = 1'b1;
          end
        end else if (w_byte_to) begin
          w_retry_req = 1'b1;
        end
      end
      StWaitBat: begin
        if (rx_valid) begin
          if (rx_data == RSP_BAT_OK) begin
            w_idx_nxt   = r_idx + 3'd1;
            w_state_nxt = StNext;
          end else if (rx_data == RSP_BAT_FAIL) begin
            w_retry_req = 1'b1;
          end
        end else if (w_bat_to) begin
          w_retry_req = 1'b1;
        end
      end
      StNext: begin
        if (r_idx == 3'd4) begin
          w_state_nxt = StDone;
        end else begin
          w_retry_nxt = 2'd0;
          w_state_nxt = StInhibit;
        end
      end
      default: w_state_nxt = StIdle;
    endcase

    if (w_retry_req) begin
      if (r_retry < RetryMax) begin
        w_retry_nxt = r_retry + 2'd1;
        w_state_nxt = StInhibit;
      end else begin
        w_state_nxt = StError;
      end
    end
  end

  // The BAT wait gets its own window, measured from entry to WAIT_BAT.
  assign w_timer_clr = ((w_state_nxt == StInhibit) && (r_state != StInhibit)) ||
                       ((w_state_nxt == StWaitBat) && (r_state != StWaitBat));

  assign w_host_owns = w_state_nxt inside {StInhibit, StStart, StTxBits, StTxAck, StWaitIdle};

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_idx       <= '0;
      r_retry     <= '0;
      r_timer     <= '0;
      r_clk_oe    <= 1'b0;
      r_rx_enable <= 1'b1;
      r_ready     <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_retry <= w_retry_nxt;
      if (w_timer_clr) begin
        r_timer <= '0;
      end else if (r_timer != '1) begin
        r_timer <= r_timer + TimerW'(1);
      end
      // Clock stays held through START so data is already low when it is released.
      r_clk_oe    <= (w_state_nxt == StInhibit) || (w_state_nxt == StStart);
      r_rx_enable <= ~w_host_owns;
      r_ready     <= (w_state_nxt == StDone);
      r_error     <= (w_state_nxt == StError);
    end
  end

  assign ps2_clk_oe = r_clk_oe;
  assign ps2_dat_oe = w_dat_oe;
  assign rx_enable  = r_rx_enable;
  assign ready      = r_ready;
  assign error      = r_error;
  assign dbg_state  = r_state;

endmodule
